// File: rtl/div_unit.sv
// div_unit: iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
//
// Restoring radix-2 divider, one quotient bit per cycle. Divide-by-zero and
// signed overflow are resolved in NORM without iterating.
//
// Optional build macro DIV_EARLY_OUT_EN:
//   defined   - a clz_encoder skips the dividend's leading zero bits, and
//               a zero dividend or a dividend smaller than the divisor
//               completes straight from NORM.
//   undefined - every non-special operation takes 32 iterations.
// Results are identical in both builds; only the latency differs.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   start_i    request, sampled only while idle
//   op_i       funct3[1:0]: bit0 = unsigned, bit1 = remainder
//   dividend_i rs1, sampled with start_i
//   divisor_i  rs2, sampled with start_i
//   busy_o     high from the cycle after accept through FIXUP
//   done_o     one-cycle pulse, result_o valid from this cycle
//   result_o   quotient or remainder, held until the next done_o
//
// Handshake: start_i is a request that is taken only when the unit is idle
// (busy_o low, which includes the done_o cycle); requests while busy_o is
// high are dropped. done_o is a single-cycle completion strobe with no
// back-pressure. The FSM state is the signal "state" for checkers.

`ifdef DIV_EARLY_OUT_EN
// Count of leading zeros of a 32-bit value; 32 when the value is zero.
module clz_encoder (
  input  logic [31:0] value,
  output logic [5:0]  count
);
  always_comb begin
    count = 6'd32;
    // Ascending scan: the last hit is the most significant set bit.
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end
endmodule
`endif

module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, NORM, ITER, FIXUP} state_t;

  state_t          state;
  logic            op_rem;   // select remainder in FIXUP
  logic            neg_q;    // signed op with differing operand signs
  logic            neg_r;    // signed op with negative dividend
  logic            special;  // result already final, skip sign fixup
  logic [XLEN-1:0] dvd;      // |dividend|, then shifted into the quotient
  logic [XLEN-1:0] dsr;      // |divisor|
  logic [XLEN-1:0] rem;      // partial remainder, always < dsr
  logic [5:0]      cnt;

  // Operand capture: absolute values only for signed ops.
  logic            acc_signed;
  logic            acc_neg_a;
  logic            acc_neg_b;
  assign acc_signed = ~op_i[0];
  assign acc_neg_a  = acc_signed & dividend_i[XLEN-1];
  assign acc_neg_b  = acc_signed & divisor_i[XLEN-1];

  // Raw dividend rebuilt from its magnitude and sign.
  logic [XLEN-1:0] dvd_raw;
  assign dvd_raw = neg_r ? -dvd : dvd;

  // Signed overflow: -2^31 / -1. The divisor's sign is neg_q ^ neg_r,
  // which is zero for unsigned ops, so no separate op check is needed.
  logic ovf;
  assign ovf = (dvd == 32'h8000_0000) && (dsr == 32'd1) && (neg_q ^ neg_r);

  logic [5:0]      n;
  logic [XLEN-1:0] dvd_norm;
`ifdef DIV_EARLY_OUT_EN
  logic [5:0] clz;
  clz_encoder u_clz (
    .value (dvd),
    .count (clz)
  );
  assign n        = 6'd32 - clz;
  assign dvd_norm = dvd << clz;
`else
  assign n        = 6'd32;
  assign dvd_norm = dvd;
`endif

  // One restoring step. rem < dsr, so rem_sh < 2*dsr and the 33-bit
  // difference is below 2^32 when non-negative: bit 32 is its sign.
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          ge;
  assign rem_sh = {rem, dvd[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dsr};
  assign ge     = ~diff[XLEN];

  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  assign q_fix = (!special && neg_q) ? -dvd : dvd;
  assign r_fix = (!special && neg_r) ? -rem : rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      special  <= 1'b0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      cnt      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            op_rem <= op_i[1];
            neg_r  <= acc_neg_a;
            neg_q  <= acc_neg_a ^ acc_neg_b;
            dvd    <= acc_neg_a ? -dividend_i : dividend_i;
            dsr    <= acc_neg_b ? -divisor_i : divisor_i;
            busy_o <= 1'b1;
            state  <= NORM;
          end
        end
        NORM: begin
          rem     <= '0;
          cnt     <= '0;
          special <= 1'b1;
          state   <= FIXUP;
          if (dsr == '0) begin
            dvd <= '1;
            rem <= dvd_raw;
          end else if (ovf) begin
            dvd <= 32'h8000_0000;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (dvd == '0) begin
            dvd <= '0;
          end else if (dvd < dsr) begin
            dvd <= '0;
            rem <= dvd_raw;
          end
`endif
          else begin
            special <= 1'b0;
            dvd     <= dvd_norm;
            cnt     <= n;
            if (n != 6'd0) state <= ITER;
          end
        end
        ITER: begin
          rem <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          dvd <= {dvd[XLEN-2:0], ge};
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= FIXUP;
        end
        FIXUP: begin
          result_o <= op_rem ? r_fix : q_fix;
          done_o   <= 1'b1;
          busy_o   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) in the execute stage.
- Consumes the 6-bit count from a clz_encoder instance to skip leading-zero iterations of the dividend.
- Sits beside the ALU and talks to the pipeline controller via a start/busy/done handshake.
- Result is held until the next operation completes.

Parameters:
- XLEN, 32, operand width; only 32 is supported because clz_encoder is 32-bit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start_i  input  1  request; sampled only in IDLE.
- op_i  input  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
  - bit0 = unsigned, bit1 = remainder.
- dividend_i  input  32  rs1 value, sampled with start_i.
- divisor_i  input  32  rs2 value, sampled with start_i.
- busy_o  output  1  high from the cycle after accept through FIXUP.
- done_o  output  1  one-cycle pulse; result_o is valid from this cycle.
- result_o  output  32  quotient or remainder; held until the next done_o.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; busy_o=0, done_o=0, result_o=0; all internal registers cleared.
  - Applies mid-operation too: the in-flight op is abandoned and no done_o is produced.
- Cycle numbering: cycle 0 is the edge where start_i=1 is sampled in IDLE.
- IDLE:
  - On start_i, latch op, sign flags and |dividend|, |divisor|. Absolute values are taken only for signed ops, using two's complement.
  - Go to NORM.
- NORM (cycle 1): clz_encoder operates on latched |dividend|. Special cases are checked in priority order; each loads its result and goes to FIXUP with n=0:
  - Divisor==0: quotient=0xFFFFFFFF, remainder=dividend (raw, unsigned).
  - Signed, dividend==0x80000000 and divisor==0xFFFFFFFF: quotient=0x80000000, remainder=0.
  - Otherwise the dividend is pre-shifted left by clz, the partial remainder is cleared, and count n=32-clz.
  - Go to ITER if n>0, else FIXUP.
- ITER:
  - Restoring radix-2 step per cycle: shift {rem,dvd} left 1; if rem>=|divisor|, subtract and set quotient bit.
  - Decrement count; go to FIXUP when count reaches 0.
  - Takes exactly n cycles.
- FIXUP:
  - Signed ops only: negate quotient if sign(dividend)!=sign(divisor); remainder takes the sign of the dividend.
  - Select quotient or remainder by op bit1 and register it into result_o.
  - Register done_o=1; return to IDLE.
- Latency: done_o is high in cycle n+3; busy_o is high in cycles 1..n+2.
- start_i while busy_o=1 is ignored; operands are not resampled.
- start_i during the done_o cycle is accepted, because state is IDLE.
- Arithmetic:
  - Partial remainder is 33 bits so the compare/subtract never overflows.
  - All results are truncated to 32 bits.
  - Special-case results bypass sign fixup.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined:
  - CLZ skip as described (n=32-clz).
  - NORM also short-circuits |dividend|==0 → quotient 0, remainder 0.
  - NORM also short-circuits |dividend|<|divisor| → quotient 0, remainder=dividend.
  - Both go to FIXUP with n=0.
- Undefined:
  - clz_encoder is not instantiated; no pre-shift.
  - n is always 32 for non-special ops, so done_o is in cycle 35.
  - Divide-by-zero and overflow cases still finish in cycle 3.
  - Results are identical either way.

Test Plan:
- DIVU 100/7, then REMU 100/7 → 0x0000000E, then 0x00000002.
  - With macro: clz=25, n=7, done_o at cycle 10, busy_o high cycles 1..9.
  - Without macro: done_o at cycle 35.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - With macro: n=3, done_o at cycle 6.
- DIVU 0x1234/0 → 0xFFFFFFFF; REM 0x1234/0 → 0x00001234; DIV 5/0 → 0xFFFFFFFF.
  - All done at cycle 3 regardless of macro.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0; done_o at cycle 3.
- DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF with done_o at cycle 35.
  - start_i pulsed with other operands at cycles 5 and 20 is ignored.
  - Back-to-back start_i in the done_o cycle is accepted: REMU 3/10 → 3, done_o at cycle 3 with macro, cycle 35 without.
- rst_n=0 for one edge during ITER of DIVU 0xFFFFFFFF/3:
  - Next cycle busy_o=0, done_o=0, result_o=0, and no done_o follows.
  - A subsequent DIVU 9/3 → 3.
